// File: rtl/smg_pkg.sv
// Shared definitions for the 7-segment scan driver: FSM state encodings,
// the active-high "all segments off" constant and the hex segment table.
package smg_pkg;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_ENCODE = 2'd1;
    localparam logic [1:0] ST_ON     = 2'd2;
    localparam logic [1:0] ST_OFF    = 2'd3;

    localparam logic [7:0] SEG_OFF   = 8'h00;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] smg_hex2seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/smg_hex_encoder.sv
// Combinational nibble + decimal point -> active-high {dp,g,f,e,d,c,b,a}.
module smg_hex_encoder
    import smg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    assign pattern = {dp, smg_hex2seg(nibble)};

endmodule

// File: rtl/smg_scan_ctrl.sv
// Time-multiplexed 7-segment scan driver with brightness PWM, ghost blanking
// between digits and a frame-coherent input snapshot.
// Optional build macro SMG_LZ_SUPPRESS_EN: leading zero digits are darkened
// (segments a-g off, decimal point still honoured, digit 0 never suppressed).
//
// state     | meaning
// ST_LOAD   | one cycle: sample bright; at digit 0 also snapshot the inputs
// ST_ENCODE | one cycle: nibble -> segment pattern into the output register
// ST_ON     | 16 brightness sub-steps of SUB_CYCLES each; digit lit while step <= bright
// ST_OFF    | BLANK_CYCLES with everything dark to stop ghosting into the next digit
module smg_scan_ctrl
    import smg_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int SUB_CYCLES   = 3000,
    parameter int BLANK_CYCLES = 2000,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit SCAN_ACT_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   number_sig,
    input  logic [DIGITS-1:0]     dp_sig,
    input  logic [DIGITS-1:0]     blank_sig,
    input  logic [3:0]            bright,
    output logic [7:0]            smg_data,
    output logic [DIGITS-1:0]     scan_sig,
    output logic                  frame_done
);

    localparam int CNT_MAX = (SUB_CYCLES > BLANK_CYCLES) ? SUB_CYCLES : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     SUB_LAST   = CW'(SUB_CYCLES - 1);
    localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0]     DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [7:0]        SEG_POL    = {8{SEG_ACT_LOW}};
    localparam logic [DIGITS-1:0] SCAN_POL   = {DIGITS{SCAN_ACT_LOW}};
    localparam logic [DIGITS-1:0] SCAN_ONE   = DIGITS'(1);

    logic [1:0]          state_q, state_nxt;
    logic [CW-1:0]       cnt_q, cnt_nxt;
    logic [3:0]          step_q, step_nxt;
    logic [DW-1:0]       digit_q, digit_nxt;
    logic [4*DIGITS-1:0] number_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   blank_q;
    logic [3:0]          bright_q;
    logic [DIGITS-1:0]   lz_mask;
    logic [7:0]          enc_pat;
    logic [7:0]          seg_nxt;
    logic [DIGITS-1:0]   scan_nxt;
    logic                blank_cur;

    assign blank_cur = blank_q[digit_q];

    smg_hex_encoder u_enc (
        .nibble  (number_q[{digit_q, 2'b00} +: 4]),
        .dp      (dp_q[digit_q]),
        .pattern (enc_pat)
    );

    // Leading-zero mask from the frame snapshot, scanned from the top digit down.
    always_comb begin
        lz_mask = '0;
`ifdef SMG_LZ_SUPPRESS_EN
        begin
            logic seen;
            seen = 1'b0;
            for (int i = DIGITS - 1; i > 0; i--) begin
                if (number_q[i*4 +: 4] != 4'h0) seen = 1'b1;
                if (!seen) lz_mask[i] = 1'b1;
            end
        end
`endif
    end

    // State register, slot counters, per-slot brightness and frame snapshot.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            step_q   <= '0;
            digit_q  <= '0;
            number_q <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            bright_q <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            step_q  <= step_nxt;
            digit_q <= digit_nxt;
            if (state_q == ST_LOAD) begin
                bright_q <= bright;
                if (digit_q == '0) begin
                    number_q <= number_sig;
                    dp_q     <= dp_sig;
                    blank_q  <= blank_sig;
                end
            end
        end
    end

    // Next-state and counter sequencing for one digit slot.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        step_nxt  = step_q;
        digit_nxt = digit_q;
        case (state_q)
            ST_LOAD: state_nxt = ST_ENCODE;
            ST_ENCODE: begin
                state_nxt = ST_ON;
                cnt_nxt   = '0;
                step_nxt  = '0;
            end
            ST_ON: begin
                if (cnt_q == SUB_LAST) begin
                    cnt_nxt = '0;
                    if (step_q == 4'hF) state_nxt = ST_OFF;
                    else                step_nxt  = step_q + 4'd1;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_LOAD;
                    digit_nxt = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Output decode: values for the coming cycle, so the output registers line up with the state.
    always_comb begin
        seg_nxt    = SEG_OFF;
        scan_nxt   = '0;
        frame_done = (state_q == ST_OFF) && (cnt_q == BLANK_LAST) && (digit_q == DIGIT_LAST);
        if (state_nxt == ST_ON && !blank_cur) begin
            if (state_q == ST_ENCODE)
                seg_nxt = lz_mask[digit_q] ? {enc_pat[7], 7'b0} : enc_pat;
            else
                seg_nxt = smg_data ^ SEG_POL;
            if (step_nxt <= bright_q)
                scan_nxt = SCAN_ONE << digit_q;
        end
    end

    // Output registers with board polarity applied.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            smg_data <= SEG_OFF ^ SEG_POL;
            scan_sig <= SCAN_POL;
        end else begin
            smg_data <= seg_nxt ^ SEG_POL;
            scan_sig <= scan_nxt ^ SCAN_POL;
        end
    end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Self-checking bench for smg_scan_ctrl (DIGITS=6, SUB_CYCLES=4, BLANK_CYCLES=3).
module tb_smg_scan_ctrl;

    localparam int ND        = 6;
    localparam int SUB       = 4;
    localparam int BLK       = 3;
    localparam int ON_FIRST  = 2;
    localparam int ON_LAST   = ON_FIRST + 16*SUB - 1;
    localparam int SLOT_LAST = ON_LAST + BLK;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [23:0]   number_sig = '0;
    logic [5:0]    dp_sig = '0;
    logic [5:0]    blank_sig = '0;
    logic [3:0]    bright = '0;
    logic [7:0]    smg_data;
    logic [5:0]    scan_sig;
    logic          frame_done;

    smg_scan_ctrl #(
        .DIGITS(ND), .SUB_CYCLES(SUB), .BLANK_CYCLES(BLK),
        .SEG_ACT_LOW(1'b1), .SCAN_ACT_LOW(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST), .number_sig(number_sig), .dp_sig(dp_sig),
        .blank_sig(blank_sig), .bright(bright), .smg_data(smg_data),
        .scan_sig(scan_sig), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [23:0] num;
        logic [5:0]  dp;
        logic [5:0]  blank;
        logic [3:0]  bright;
    } vec_t;

    typedef struct {
        logic [7:0] seg;
        logic [5:0] scan;
        int         active;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] seg_tab [16];
    vec_t       tv [5];
    int         total = 0;
    int         bad = 0;
    int         pos, dig;
    logic [7:0] seg_seen;
    int         act_cnt, shape_err, fd_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t expect_slot(input vec_t v, input int d);
        exp_t       e;
        logic [3:0] nib;
        bit         supp;
        nib  = v.num[d*4 +: 4];
        supp = 1'b0;
`ifdef SMG_LZ_SUPPRESS_EN
        if (d != 0 && (v.num >> (4*d)) == 24'h0) supp = 1'b1;
`endif
        if (v.blank[d]) begin
            e.seg = 8'hFF; e.scan = 6'h3F; e.active = 0;
        end else begin
            e.seg = supp ? 8'hFF : seg_tab[nib];
            if (v.dp[d]) e.seg[7] = 1'b0;
            e.scan   = ~(6'b000001 << d);
            e.active = (int'(v.bright) + 1) * SUB;
        end
        return e;
    endfunction

    task automatic push_digits(input vec_t v, input int lo, input int hi);
        for (int d = lo; d <= hi; d++) sb.push_back(expect_slot(v, d));
    endtask

    task automatic apply(input vec_t v);
        number_sig = v.num; dp_sig = v.dp; blank_sig = v.blank; bright = v.bright;
    endtask

    task automatic clear_acc();
        seg_seen = 8'h00; act_cnt = 0; shape_err = 0; fd_err = 0;
    endtask

    task automatic release_rst();
        sb.delete();
        RST = 1'b0;
        pos = 1;
        dig = 0;
        clear_acc();
    endtask

    task automatic do_reset(input vec_t v);
        @(negedge CLK);
        RST = 1'b1;
        apply(v);
        repeat (3) @(negedge CLK);
        release_rst();
    endtask

    task automatic observe();
        exp_t e;
        bit   have, want;
        have = (sb.size() > 0);
        if (have) e = sb[0];
        if (frame_done !== (dig == ND-1 && pos == SLOT_LAST)) fd_err++;
        if (pos >= ON_FIRST && pos <= ON_LAST) begin
            if (pos == ON_FIRST) seg_seen = smg_data;
            else if (smg_data !== seg_seen) shape_err++;
            want = have && ((pos - ON_FIRST) < e.active);
            if (scan_sig !== (want ? e.scan : 6'h3F)) shape_err++;
            if (scan_sig !== 6'h3F) act_cnt++;
        end else if (smg_data !== 8'hFF || scan_sig !== 6'h3F) begin
            shape_err++;
        end
    endtask

    task automatic finish_slot();
        exp_t e;
        if (sb.size() == 0) begin
            check($sformatf("scoreboard_empty_d%0d", dig), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("seg_d%0d", dig), 32'(seg_seen), 32'(e.seg));
            check($sformatf("active_cycles_d%0d", dig), 32'(act_cnt), 32'(e.active));
            check($sformatf("slot_shape_d%0d", dig), 32'(shape_err), 32'd0);
            check($sformatf("frame_done_d%0d", dig), 32'(fd_err), 32'd0);
        end
        clear_acc();
    endtask

    task automatic run_slots(input int n);
        int done;
        done = 0;
        while (done < n) begin
            @(negedge CLK);
            observe();
            if (pos == SLOT_LAST) begin
                finish_slot();
                done++;
                pos = 0;
                dig = (dig + 1) % ND;
            end else begin
                pos++;
            end
        end
    endtask

    initial begin
        vec_t va, vb, vw;
        int   rerr;
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        tv[0] = '{num: 24'h1234AF, dp: 6'b000000, blank: 6'b000000, bright: 4'd15};
        tv[1] = '{num: 24'h1234AF, dp: 6'b000000, blank: 6'b000000, bright: 4'd3};
        tv[2] = '{num: 24'h0789BC, dp: 6'b000001, blank: 6'b000100, bright: 4'd0};
        tv[3] = '{num: 24'hDE5601, dp: 6'b101010, blank: 6'b100001, bright: 4'd7};
        tv[4] = '{num: 24'h0000A0, dp: 6'b010000, blank: 6'b000000, bright: 4'd15};

        #1 RST = 1'b1;
        apply(tv[0]);
        repeat (2) @(negedge CLK);
        check("reset_smg_data", 32'(smg_data), 32'h0FF);
        check("reset_scan_sig", 32'(scan_sig), 32'h03F);
        check("reset_frame_done", 32'(frame_done), 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_reset(tv[i]);
            push_digits(tv[i], 0, ND-1);
            if (i == 0) push_digits(tv[i], 0, ND-1);
            run_slots((i == 0) ? 2*ND : ND);
        end

        // reset in the middle of digit 1's ON phase
        do_reset(tv[0]);
        push_digits(tv[0], 0, 0);
        run_slots(1);
        repeat (30) @(negedge CLK);
        check("pre_reset_scan_d1", 32'(scan_sig), 32'h03D);
        RST = 1'b1;
        #1;
        check("async_reset_smg_data", 32'(smg_data), 32'h0FF);
        check("async_reset_scan_sig", 32'(scan_sig), 32'h03F);
        check("async_reset_frame_done", 32'(frame_done), 32'd0);
        vw = '{num: 24'h9D5678, dp: 6'b000010, blank: 6'b000000, bright: 4'd1};
        apply(vw);
        rerr = 0;
        repeat (5) begin
            @(negedge CLK);
            if (smg_data !== 8'hFF || scan_sig !== 6'h3F || frame_done !== 1'b0) rerr++;
        end
        check("reset_hold_outputs", 32'(rerr), 32'd0);
        release_rst();
        push_digits(vw, 0, 1);
        run_slots(2);

        // input changes mid-frame: digits keep the snapshot, brightness follows per digit
        va = tv[0];
        do_reset(va);
        vb = va;
        vb.bright = 4'd1;
        push_digits(va, 0, 2);
        push_digits(vb, 3, ND-1);
        run_slots(3);
        apply(vw);
        run_slots(3);
        push_digits(vw, 0, ND-1);
        run_slots(ND);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
